// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: state encoding,
// RV32I base opcodes and the opcode classification record.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  typedef struct packed {
    logic legal;
    logic is_mem;
    logic is_store;
    logic is_branch;
    logic writes_rd;
  } opclass_t;

endpackage

// File: rtl/multicycle_ctrl_opclass.sv
// Combinational opcode classifier: tells the sequencer which path an
// instruction takes through EXEC/MEM/WB and whether it writes rd.
module ctrl_opclass
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OPIMM: begin
        cls.legal     = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OP_LOAD: begin
        cls.legal     = 1'b1;
        cls.is_mem    = 1'b1;
        cls.writes_rd = 1'b1;
      end
      OP_STORE: begin
        cls.legal    = 1'b1;
        cls.is_mem   = 1'b1;
        cls.is_store = 1'b1;
      end
      OP_BRANCH: begin
        cls.legal     = 1'b1;
        cls.is_branch = 1'b1;
      end
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle RV32I core: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and strobes IR/PC/RF write enables.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err,
  output logic [31:0] retired
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [31:0] retired_q, retired_d;
  opclass_t    cls;
  logic        rd_is_zero;
  logic        unused_inst;

  assign unused_inst = ^inst[31:12];
  assign rd_is_zero  = (inst[11:7] == 5'd0);

  ctrl_opclass u_opclass (
    .opcode (inst[6:0]),
    .cls    (cls)
  );

  always_comb begin
    state_d   = state_q;
    tmo_d     = 8'd0;
    err_d     = err_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (cls.legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_EXEC: begin
        if (cls.is_mem) begin
          state_d = S_MEM;
        end else if (cls.is_branch) begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      // A store retires straight out of MEM; a load still needs WB.
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.is_store;
        if (dmem_ready) begin
          if (cls.is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        rf_we   = cls.writes_rd && !rd_is_zero;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
    retired_d = pc_we ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      tmo_q     <= 8'd0;
      err_q     <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction classes, wait states,
// reset mid-access, illegal opcode and fetch timeout on a second instance.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [31:0] inst, inst2;
  logic        imem_ready, dmem_ready, imem_ready2, dmem_ready2;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted, err;
  logic        imem_req2, dmem_req2, dmem_we2, ir_we2, pc_we2, rf_we2, halted2, err2;
  logic [2:0]  state, state2;
  logic [31:0] retired, retired2;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;
  int cyc;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .inst(inst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .state(state), .halted(halted), .err(err),
    .retired(retired)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_tmo (
    .clk(clk), .rst(rst2), .inst(inst2), .imem_ready(imem_ready2), .dmem_ready(dmem_ready2),
    .imem_req(imem_req2), .dmem_req(dmem_req2), .dmem_we(dmem_we2), .ir_we(ir_we2),
    .pc_we(pc_we2), .rf_we(rf_we2), .state(state2), .halted(halted2), .err(err2),
    .retired(retired2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; cyc = 0;
    inst = 32'h0; inst2 = 32'h0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_ready2 = 1'b0; dmem_ready2 = 1'b0;
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_err_halted", {30'd0, err, halted}, 32'd0);
    #8 rst = 1'b0;
    step();
    chk("init_to_fetch", 32'(state), 32'd1);
    chk("fetch_req", 32'(imem_req), 32'd1);

    // add x3, x1, x2 with zero-wait fetch
    inst = 32'h002081B3; imem_ready = 1'b1; cyc = 0; #1;
    chk("add_ir_we", 32'(ir_we), 32'd1);
    step(); imem_ready = 1'b0; #1;
    chk("add_decode", {29'd0, state}, 32'd2);
    chk("add_decode_strobes", {28'd0, imem_req, ir_we, pc_we, rf_we}, 32'd0);
    step();
    chk("add_exec", 32'(state), 32'd3);
    step();
    chk("add_wb", 32'(state), 32'd5);
    chk("add_wb_strobes", {30'd0, rf_we, pc_we}, 32'd3);
    step();
    chk("add_cycles", 32'(cyc), 32'd4);
    chk("add_back_fetch", 32'(state), 32'd1);
    chk("add_retired", retired, 32'd1);

    // lw x5, 0(x0) with three wait states on dmem
    inst = 32'h00002283; imem_ready = 1'b1; cyc = 0; #1;
    step(); imem_ready = 1'b0;
    step();
    step();
    chk("lw_mem", 32'(state), 32'd4);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3); #1;
      if (dmem_req) cnt++;
      chk("lw_mem_we", {30'd0, dmem_we, pc_we}, 32'd0);
      step();
    end
    dmem_ready = 1'b0; #1;
    chk("lw_req_cycles", 32'(cnt), 32'd4);
    chk("lw_wb", 32'(state), 32'd5);
    chk("lw_wb_strobes", {30'd0, rf_we, pc_we}, 32'd3);
    step();
    chk("lw_cycles", 32'(cyc), 32'd8);
    chk("lw_retired", retired, 32'd2);

    // sw x2, 0(x0) zero-wait
    inst = 32'h00202023; imem_ready = 1'b1; #1;
    step(); imem_ready = 1'b0;
    step();
    step();
    dmem_ready = 1'b1; #1;
    chk("sw_mem", 32'(state), 32'd4);
    chk("sw_strobes", {28'd0, dmem_req, dmem_we, pc_we, rf_we}, 32'hE);
    step(); dmem_ready = 1'b0; #1;
    chk("sw_back_fetch", 32'(state), 32'd1);

    // beq x0, x0, 0
    inst = 32'h00000063; imem_ready = 1'b1; #1;
    step(); imem_ready = 1'b0;
    step();
    chk("beq_exec", 32'(state), 32'd3);
    chk("beq_strobes", {30'd0, pc_we, rf_we}, 32'd2);
    step();
    chk("beq_back_fetch", 32'(state), 32'd1);
    chk("sw_beq_retired", retired, 32'd4);

    // addi x0, x0, 0: WB without register write
    inst = 32'h00000013; imem_ready = 1'b1; #1;
    step(); imem_ready = 1'b0;
    step();
    step();
    chk("addi0_wb", 32'(state), 32'd5);
    chk("addi0_strobes", {30'd0, rf_we, pc_we}, 32'd1);
    step();
    chk("addi0_retired", retired, 32'd5);

    // reset in the middle of a load access
    inst = 32'h00002283; imem_ready = 1'b1; #1;
    step(); imem_ready = 1'b0;
    step();
    step();
    chk("mid_mem_req", 32'(dmem_req), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_outs", {26'd0, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we}, 32'd0);
    chk("mid_rst_retired", retired, 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_init", 32'(state), 32'd0);
    step();
    chk("post_rst_fetch", 32'(state), 32'd1);

    // illegal opcode, then imem_ready held high in HALT
    inst = 32'h0000007F; imem_ready = 1'b1; #1;
    step();
    chk("ill_decode", 32'(state), 32'd2);
    step();
    chk("ill_halt", 32'(state), 32'd7);
    chk("ill_err_halted", {30'd0, err, halted}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_quiet", {25'd0, imem_req, dmem_req, ir_we, pc_we, rf_we, state == 3'd7, err}, 32'd3);
    end
    imem_ready = 1'b0;

    // fetch timeout on the MEM_TIMEOUT=4 instance
    rst2 = 1'b0;
    step();
    chk("tmo_fetch", 32'(state2), 32'd1);
    cnt = 0;
    while (state2 == 3'd1 && cnt < 10) begin
      cnt++;
      step();
    end
    chk("tmo_fetch_cycles", 32'(cnt), 32'd4);
    chk("tmo_halt", 32'(state2), 32'd7);
    chk("tmo_err_req", {29'd0, err2, halted2, imem_req2}, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
